// File: rtl/alu_seq.sv
// alu_seq: handshaked integer ALU with registered result and iterative shifter
// Ports:
//   clk, rst_i                 clock, synchronous active-high reset
//   valid_i, ready_o           request handshake (op_i, a_i, b_i captured on accept)
//   valid_o, ready_i           result handshake (result_o and flags held until taken)
//   result_o                   registered result
//   overflow_o, carry_o        signed overflow and carry/borrow, ADD/SUB only
//   zero_o, illegal_o          result is zero, op code unassigned
//   busy_o                     an operation is in flight or its result is pending
module alu_seq #(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] result_o,
  output logic             overflow_o,
  output logic             carry_o,
  output logic             zero_o,
  output logic             illegal_o,
  output logic             busy_o
);
  localparam int AW = $clog2(WIDTH);
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_SLL = 4'd2, OP_SRL = 4'd3, OP_SRA = 4'd4;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d, res_q, res_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic             ov_q, ov_d, c_q, c_d, z_q, z_d, ill_q, ill_d;
  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu_r, sra, sh_nxt;
  logic [AW-1:0]    amt, step;
  logic             alu_ov, alu_c, is_shift, accept;
  assign amt      = b_i[AW-1:0];
  assign is_shift = op_i == OP_SLL || op_i == OP_SRL || op_i == OP_SRA;
  assign ready_o  = !rst_i && (state_q == IDLE || (state_q == DONE && ready_i));
  assign accept   = valid_i && ready_o;
  assign sum      = {1'b0, a_i} + {1'b0, b_i};
  assign diff     = {1'b0, a_i} - {1'b0, b_i};
  // last step may be shorter than SHIFT_STEP; compare one bit wider so SHIFT_STEP==WIDTH fits
  assign step     = ({1'b0, cnt_q} < (AW+1)'(SHIFT_STEP)) ? cnt_q : AW'(SHIFT_STEP);
  // kept as its own assignment so the arithmetic shift is not made unsigned by a mixed ternary
  assign sra      = $signed(sh_q) >>> step;
  assign sh_nxt   = op_q == OP_SLL ? sh_q << step : op_q == OP_SRL ? sh_q >> step : sra;
  always_comb begin
    alu_r  = '0;
    alu_ov = 1'b0;
    alu_c  = 1'b0;
    case (op_i)
      OP_ADD: begin
        alu_r  = sum[WIDTH-1:0];
        alu_c  = sum[WIDTH];
        alu_ov = (a_i[WIDTH-1] == b_i[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SUB: begin
        alu_r  = diff[WIDTH-1:0];
        alu_c  = diff[WIDTH];
        alu_ov = (a_i[WIDTH-1] != b_i[WIDTH-1]) && (diff[WIDTH-1] != a_i[WIDTH-1]);
      end
      OP_SLL, OP_SRL, OP_SRA: alu_r = a_i;
      4'd5: alu_r = a_i & b_i;
      4'd6: alu_r = a_i | b_i;
      4'd7: alu_r = a_i ^ b_i;
      4'd8: alu_r = WIDTH'($signed(a_i) < $signed(b_i));
      4'd9: alu_r = WIDTH'(a_i < b_i);
      default: alu_r = '0;
    endcase
  end
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    res_d   = res_q;
    ov_d    = ov_q;
    c_d     = c_q;
    z_d     = z_q;
    ill_d   = ill_q;
    if (state_q == SHIFT) begin
      sh_d  = sh_nxt;
      cnt_d = cnt_q - step;
      if (cnt_q == step) begin
        state_d = DONE;
        res_d   = sh_nxt;
        z_d     = sh_nxt == '0;
        ov_d    = 1'b0;
        c_d     = 1'b0;
        ill_d   = 1'b0;
      end
    end else if (state_q == DONE && ready_i) state_d = IDLE;
    if (accept) begin
      op_d  = op_i;
      sh_d  = a_i;
      cnt_d = amt;
      if (is_shift && amt != '0) state_d = SHIFT;
      else begin
        state_d = DONE;
        res_d   = alu_r;
        ov_d    = alu_ov;
        c_d     = alu_c;
        ill_d   = op_i > 4'd9;
        z_d     = alu_r == '0 && op_i <= 4'd9;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      res_q   <= '0;
      ov_q    <= 1'b0;
      c_q     <= 1'b0;
      z_q     <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      res_q   <= res_d;
      ov_q    <= ov_d;
      c_q     <= c_d;
      z_q     <= z_d;
      ill_q   <= ill_d;
    end
  end
  assign valid_o    = state_q == DONE;
  assign busy_o     = state_q != IDLE;
  assign result_o   = res_q;
  assign overflow_o = ov_q;
  assign carry_o    = c_q;
  assign zero_o     = z_q;
  assign illegal_o  = ill_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: table-driven and scoreboard checks of alu_seq
module tb_alu_seq;
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a, b, r;
    logic        ov, c, z, ill;
  } vec_t;
  localparam longint MAXS = 2147483647;
  localparam longint MINS = -MAXS - 1;
  logic        clk = 1'b0, rst_i = 1'b1, valid_i = 1'b0, ready_i = 1'b1;
  logic [3:0]  op_i = '0;
  logic [31:0] a_i = '0, b_i = '0;
  logic        ready_o, valid_o, overflow_o, carry_o, zero_o, illegal_o, busy_o;
  logic [31:0] result_o;
  logic        v4 = 1'b0, rdy4 = 1'b1;
  logic [3:0]  op4 = '0;
  logic [31:0] a4 = '0, b4 = '0;
  logic        r4o, val4, ov4, c4, z4, il4, bz4;
  logic [31:0] res4;
  vec_t        sb[$];
  vec_t        mv;
  vec_t        tbl[17];
  int          n_chk = 0, n_fail = 0;
  alu_seq #(.WIDTH(32), .SHIFT_STEP(1)) dut (
    .clk(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
    .overflow_o(overflow_o), .carry_o(carry_o), .zero_o(zero_o), .illegal_o(illegal_o),
    .busy_o(busy_o));
  alu_seq #(.WIDTH(32), .SHIFT_STEP(4)) dut4 (
    .clk(clk), .rst_i(rst_i), .valid_i(v4), .ready_o(r4o), .op_i(op4),
    .a_i(a4), .b_i(b4), .valid_o(val4), .ready_i(rdy4), .result_o(res4),
    .overflow_o(ov4), .carry_o(c4), .zero_o(z4), .illegal_o(il4), .busy_o(bz4));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, b, r,
                              input logic ov, c, z, ill);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.r = r; v.ov = ov; v.c = c; v.z = z; v.ill = ill;
    return v;
  endfunction
  function automatic vec_t model(input logic [3:0] op, input logic [31:0] a, b);
    vec_t   v;
    longint s;
    v = mk(op, a, b, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    case (op)
      4'd0: begin
        v.r  = a + b;
        v.c  = (64'(a) + 64'(b)) > 64'hFFFF_FFFF;
        s    = longint'($signed(a)) + longint'($signed(b));
        v.ov = s > MAXS || s < MINS;
      end
      4'd1: begin
        v.r  = a - b;
        v.c  = a < b;
        s    = longint'($signed(a)) - longint'($signed(b));
        v.ov = s > MAXS || s < MINS;
      end
      4'd2: v.r = a << b[4:0];
      4'd3: v.r = a >> b[4:0];
      4'd4: begin
        s   = longint'($signed(a)) >>> b[4:0];
        v.r = s[31:0];
      end
      4'd5: v.r = a & b;
      4'd6: v.r = a | b;
      4'd7: v.r = a ^ b;
      4'd8: v.r = {31'h0, $signed(a) < $signed(b)};
      4'd9: v.r = {31'h0, a < b};
      default: v.ill = 1'b1;
    endcase
    v.z = v.r == 32'h0 && !v.ill;
    return v;
  endfunction
  always @(negedge clk) begin
    if (!rst_i && valid_o && ready_i) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL sb_unexpected: got result %h with no pending operation", result_o);
      end else begin
        mv = sb.pop_front();
        chk($sformatf("sb_result op%0d a=%h b=%h", mv.op, mv.a, mv.b), result_o, mv.r);
        chk($sformatf("sb_overflow op%0d", mv.op), 32'(overflow_o), 32'(mv.ov));
        chk($sformatf("sb_carry op%0d", mv.op), 32'(carry_o), 32'(mv.c));
        chk($sformatf("sb_zero op%0d", mv.op), 32'(zero_o), 32'(mv.z));
        chk($sformatf("sb_illegal op%0d", mv.op), 32'(illegal_o), 32'(mv.ill));
      end
    end
  end
  // called and returns at 1 time unit after a rising edge, valid_i left asserted
  task automatic send(input vec_t e, output int w);
    bit ok = 0;
    op_i = e.op; a_i = e.a; b_i = e.b; valid_i = 1'b1; w = 0;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (ready_o) begin
        ok = 1;
        sb.push_back(e);
      end else w++;
      @(posedge clk); #1;
      if (!ok) ready_i = 1'b1;
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: op %0d not accepted within 200 cycles", e.op);
    end
  endtask
  task automatic drain(input string nm);
    bit done = 0;
    valid_i = 1'b0;
    for (int k = 0; k < 200 && !done; k++) begin
      @(negedge clk);
      done = sb.size() == 0 && !busy_o;
      @(posedge clk); #1;
    end
    chk({nm, "_drain"}, 32'(done), 32'd1);
  endtask
  task automatic lat_op(input vec_t e, input int exp_lat, input string nm);
    int w, lat = 0;
    send(e, w);
    valid_i = 1'b0;
    for (int k = 1; k < 100 && lat == 0; k++) begin
      @(negedge clk);
      if (valid_o) lat = k;
      else begin
        chk({nm, "_busy"}, 32'(busy_o), 32'd1);
        chk({nm, "_ready"}, 32'(ready_o), 32'd0);
      end
      @(posedge clk); #1;
    end
    chk({nm, "_latency"}, 32'(lat), 32'(exp_lat));
  endtask
  initial begin
    int w, lat;
    bit seen;
    vec_t e;
    tbl[0]  = mk(4'd0, 32'h7FFF_FFFF, 32'h1,         32'h8000_0000, 1, 0, 0, 0);
    tbl[1]  = mk(4'd0, 32'hFFFF_FFFF, 32'h1,         32'h0,         0, 1, 1, 0);
    tbl[2]  = mk(4'd1, 32'h0,         32'h1,         32'hFFFF_FFFF, 0, 1, 0, 0);
    tbl[3]  = mk(4'd8, 32'hFFFF_FFFF, 32'h1,         32'h1,         0, 0, 0, 0);
    tbl[4]  = mk(4'd9, 32'hFFFF_FFFF, 32'h1,         32'h0,         0, 0, 1, 0);
    tbl[5]  = mk(4'd1, 32'h8000_0000, 32'h1,         32'h7FFF_FFFF, 1, 0, 0, 0);
    tbl[6]  = mk(4'd2, 32'h1234_5678, 32'h0,         32'h1234_5678, 0, 0, 0, 0);
    tbl[7]  = mk(4'hC, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0,         0, 0, 0, 1);
    tbl[8]  = mk(4'd5, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 0, 0);
    tbl[9]  = mk(4'd6, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0, 0, 0, 0);
    tbl[10] = mk(4'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 0, 0, 0, 0);
    tbl[11] = mk(4'd3, 32'h8000_0000, 32'h24,        32'h0800_0000, 0, 0, 0, 0);
    tbl[12] = mk(4'd4, 32'h8000_0000, 32'h25,        32'hFC00_0000, 0, 0, 0, 0);
    tbl[13] = mk(4'd2, 32'h1,         32'h1F,        32'h8000_0000, 0, 0, 0, 0);
    tbl[14] = mk(4'd1, 32'h5,         32'h5,         32'h0,         0, 0, 1, 0);
    tbl[15] = mk(4'hF, 32'h1,         32'h2,         32'h0,         0, 0, 0, 1);
    tbl[16] = mk(4'd4, 32'h7FFF_FFF0, 32'h44,        32'h07FF_FFFF, 0, 0, 0, 0);
    repeat (3) begin
      @(negedge clk);
      chk("reset_ready", 32'(ready_o), 32'd0);
    end
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("post_reset_ready", 32'(ready_o), 32'd1);
    chk("post_reset_valid", 32'(valid_o), 32'd0);
    chk("post_reset_busy", 32'(busy_o), 32'd0);
    chk("post_reset_result", result_o, 32'h0);
    chk("post_reset_flags", {28'h0, overflow_o, carry_o, zero_o, illegal_o}, 32'h0);
    @(posedge clk); #1;
    for (int i = 0; i < 17; i++) send(tbl[i], w);
    drain("table");
    lat_op(model(4'd4, 32'h8000_0000, 32'h25), 6, "sra5");
    lat_op(model(4'd2, 32'hA5A5_1234, 32'h0), 1, "sll0");
    lat_op(model(4'd9, 32'h3, 32'h7), 1, "sltu_lat");
    v4 = 1'b1; op4 = 4'd4; a4 = 32'h8000_0000; b4 = 32'h25;
    @(negedge clk);
    chk("step4_ready", 32'(r4o), 32'd1);
    @(posedge clk); #1;
    v4 = 1'b0;
    lat = 0;
    for (int k = 1; k < 50 && lat == 0; k++) begin
      @(negedge clk);
      if (val4) lat = k;
      @(posedge clk); #1;
    end
    chk("step4_latency", 32'(lat), 32'd3);
    chk("step4_result", res4, 32'hFC00_0000);
    ready_i = 1'b0;
    send(mk(4'd0, 32'h5, 32'h7, 32'hC, 0, 0, 0, 0), w);
    valid_i = 1'b0;
    @(negedge clk);
    chk("bp_valid_first", 32'(valid_o), 32'd1);
    repeat (3) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("bp_hold_result", result_o, 32'hC);
      chk("bp_hold_flags", {28'h0, overflow_o, carry_o, zero_o, illegal_o}, 32'h0);
      chk("bp_hold_valid", 32'(valid_o), 32'd1);
      chk("bp_ready_low", 32'(ready_o), 32'd0);
    end
    @(posedge clk); #1;
    ready_i = 1'b1;
    send(model(4'd7, 32'h1357_9BDF, 32'h0F0F_0F0F), w);
    chk("bp_release_accept", 32'(w), 32'd0);
    drain("bp");
    for (int i = 0; i < 8; i++) begin
      send(model(4'd5, $urandom, $urandom), w);
      chk("b2b_no_wait", 32'(w), 32'd0);
      if (i > 0) chk("b2b_valid", 32'(valid_o), 32'd1);
    end
    drain("b2b");
    send(model(4'd2, 32'h1, 32'h1F), w);
    valid_i = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst_i = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_ready", 32'(ready_o), 32'd0);
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);
    chk("midrst_ready_after", 32'(ready_o), 32'd1);
    chk("midrst_busy", 32'(busy_o), 32'd0);
    chk("midrst_valid", 32'(valid_o), 32'd0);
    chk("midrst_result", result_o, 32'h0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      @(negedge clk);
      seen |= valid_o;
    end
    chk("midrst_dropped", 32'(seen), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 40; i++) begin
      e = model(4'($urandom_range(0, 15)), $urandom,
                $urandom_range(0, 1) == 1 ? $urandom : 32'($urandom_range(0, 40)));
      ready_i = $urandom_range(0, 3) != 0;
      send(e, w);
    end
    ready_i = 1'b1;
    drain("random");
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
